// File: rtl/pin_debounce_if.sv
// Signal bundle between raw device pins, the debounce stage and the
// downstream pin-logic blocks.
interface pin_debounce_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] pin_in;
  logic [WIDTH-1:0] lvl_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             busy;

  // Pin/driver side: supplies raw levels, observes the conditioned result.
  modport master (
    output pin_in,
    input  lvl_out,
    input  rise,
    input  fall,
    input  busy
  );

  // Debounce stage side.
  modport slave (
    input  pin_in,
    output lvl_out,
    output rise,
    output fall,
    output busy
  );
endinterface

// File: rtl/pin_debounce.sv
// Per-channel pin conditioner: two-flop synchroniser, shared tick prescaler,
// and a stability counter that only forwards a level after it has persisted
// for STABLE ticks. Registered rise/fall strobes mark each accepted change.
module pin_debounce #(
  parameter int WIDTH    = 5,
  parameter int STABLE   = 4,
  parameter int PRESCALE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  pin_debounce_if.slave  bus
);

  localparam int CNT_W = $clog2(STABLE + 1);
  localparam int PS_W  = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE - 1);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  logic [PS_W-1:0]  ps_cnt;
  logic             tick;

  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];

  logic [WIDTH-1:0] lvl_q;
  logic [WIDTH-1:0] lvl_nxt;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_nxt;
  logic             busy_q;
  logic             busy_nxt;

  // ---- stage p0/p1: bring raw pins into the clock domain ----
  // Two-flop synchroniser; only sync_p1 is trusted downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= bus.pin_in;
      sync_p1 <= sync_p0;
    end
  end

  // Free-running prescaler; wraps at PRESCALE-1 so PRESCALE=1 ticks every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps_cnt <= '0;
    end else if (ps_cnt == PS_LAST) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  assign tick = (ps_cnt == PS_LAST);

  // ---- stage p2: stability counting and acceptance ----
  // A level different from the accepted one must survive STABLE ticks; any
  // return to the accepted level clears the count immediately.
  always_comb begin
    lvl_nxt  = lvl_q;
    rise_nxt = '0;
    fall_nxt = '0;
    busy_nxt = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt[i];
      if (sync_p1[i] == lvl_q[i]) begin
        cnt_nxt[i] = '0;
      end else if (tick && (cnt[i] == CNT_LAST)) begin
        cnt_nxt[i]  = '0;
        lvl_nxt[i]  = sync_p1[i];
        rise_nxt[i] = sync_p1[i];
        fall_nxt[i] = ~sync_p1[i];
      end else if (tick) begin
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
      busy_nxt = busy_nxt | (cnt_nxt[i] != '0);
    end
  end

  // Commit counters, accepted levels and strobes; strobes land in the same
  // cycle the new level first appears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      lvl_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      lvl_q  <= lvl_nxt;
      rise_q <= rise_nxt;
      fall_q <= fall_nxt;
      busy_q <= busy_nxt;
    end
  end

  assign bus.lvl_out = lvl_q;
  assign bus.rise    = rise_q;
  assign bus.fall    = fall_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_pin_debounce.sv
// Scoreboard bench for pin_debounce: instance A (STABLE=4, PRESCALE=1) and
// instance B (STABLE=2, PRESCALE=3). Stimulus pushes expected strobe events
// with a cycle window; a monitor pops them whenever a strobe appears.
module tb_pin_debounce;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Edge counter: after the n-th rising edge, cyc reads n.
  always @(posedge clk) cyc <= cyc + 1;

  pin_debounce_if #(.WIDTH(5)) ifa ();
  pin_debounce_if #(.WIDTH(5)) ifb ();

  pin_debounce #(.WIDTH(5), .STABLE(4), .PRESCALE(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  pin_debounce #(.WIDTH(5), .STABLE(2), .PRESCALE(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  typedef struct {
    logic [4:0] rise;
    logic [4:0] fall;
    logic [4:0] lvl;
    int         lo;
    int         hi;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input bit sel_b, input logic [4:0] r, input logic [4:0] f,
                           input logic [4:0] l, input int lo, input int hi);
    exp_t e;
    e.rise = r;
    e.fall = f;
    e.lvl  = l;
    e.lo   = lo;
    e.hi   = hi;
    if (sel_b) qb.push_back(e);
    else       qa.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic mon(input bit sel_b, input logic [4:0] r, input logic [4:0] f,
                     input logic [4:0] l);
    exp_t  e;
    int    n;
    string nm;
    nm = sel_b ? "b" : "a";
    n  = sel_b ? qb.size() : qa.size();
    if ((r != 5'd0) || (f != 5'd0)) begin
      if (n == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_strobe cyc=%0d rise=%h fall=%h required none", nm, cyc, r, f);
      end else begin
        if (sel_b) e = qb.pop_front();
        else       e = qa.pop_front();
        chk({nm, "_rise"}, 32'(r), 32'(e.rise));
        chk({nm, "_fall"}, 32'(f), 32'(e.fall));
        chk({nm, "_lvl"},  32'(l), 32'(e.lvl));
        checks++;
        if ((cyc < e.lo) || (cyc > e.hi)) begin
          errors++;
          $display("FAIL %s_timing strobe at cyc=%0d required window %0d..%0d", nm, cyc, e.lo, e.hi);
        end
      end
    end else if (n > 0) begin
      e = sel_b ? qb[0] : qa[0];
      if (cyc > e.hi) begin
        if (sel_b) void'(qb.pop_front());
        else       void'(qa.pop_front());
        checks++;
        errors++;
        $display("FAIL %s_missed_strobe rise=%h fall=%h required by cyc %0d, now %0d", nm, e.rise, e.fall, e.hi, cyc);
      end
    end
  endtask

  // Monitor: every falling edge, match presented strobes against the queues.
  initial begin
    forever begin
      @(negedge clk);
      mon(1'b0, ifa.rise, ifa.fall, ifa.lvl_out);
      mon(1'b1, ifb.rise, ifb.fall, ifb.lvl_out);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int c;
    rst_n      = 1'b0;
    ifa.pin_in = 5'h1F;
    ifb.pin_in = 5'h00;
    repeat (3) @(negedge clk);

    chk("rst_a_lvl",  32'(ifa.lvl_out), 32'h0);
    chk("rst_a_rise", 32'(ifa.rise),    32'h0);
    chk("rst_a_fall", 32'(ifa.fall),    32'h0);
    chk("rst_a_busy", 32'(ifa.busy),    32'h0);
    chk("rst_b_lvl",  32'(ifb.lvl_out), 32'h0);
    chk("rst_b_busy", 32'(ifb.busy),    32'h0);

    // Release with all pins high: accepted after the 6th edge.
    c = cyc;
    expect_ev(1'b0, 5'h1F, 5'h00, 5'h1F, c + 6, c + 6);
    rst_n = 1'b1;
    wait_until(c + 3);
    chk("accept_busy_hi", 32'(ifa.busy), 32'h1);
    wait_until(c + 5);
    chk("accept_not_early", 32'(ifa.lvl_out), 32'h0);
    wait_until(c + 7);
    chk("accept_rise_drop", 32'(ifa.rise),    32'h0);
    chk("accept_lvl_hold",  32'(ifa.lvl_out), 32'h1F);
    chk("accept_busy_lo",   32'(ifa.busy),    32'h0);

    // All pins low again.
    c = cyc;
    ifa.pin_in = 5'h00;
    expect_ev(1'b0, 5'h00, 5'h1F, 5'h00, c + 6, c + 6);
    wait_until(c + 8);

    // Glitch: three-cycle pulse on channel 0 is discarded.
    c = cyc;
    ifa.pin_in = 5'h01;
    wait_until(c + 3);
    ifa.pin_in = 5'h00;
    wait_until(c + 4);
    chk("glitch_busy_hi", 32'(ifa.busy), 32'h1);
    wait_until(c + 7);
    chk("glitch_busy_lo", 32'(ifa.busy), 32'h0);
    wait_until(c + 9);
    chk("glitch_lvl", 32'(ifa.lvl_out), 32'h0);

    // Exact threshold: four-cycle pulse on channel 2, then its fall.
    c = cyc;
    ifa.pin_in = 5'h04;
    expect_ev(1'b0, 5'h04, 5'h00, 5'h04, c + 6,  c + 6);
    expect_ev(1'b0, 5'h00, 5'h04, 5'h00, c + 10, c + 10);
    wait_until(c + 4);
    ifa.pin_in = 5'h00;
    wait_until(c + 12);

    // Prescaled instance: step up then down on channel 1.
    c = cyc;
    ifb.pin_in = 5'h02;
    expect_ev(1'b1, 5'h02, 5'h00, 5'h02, c + 6, c + 8);
    wait_until(c + 5);
    chk("b_not_early", 32'(ifb.lvl_out), 32'h0);
    wait_until(c + 12);
    chk("b_lvl_hi", 32'(ifb.lvl_out), 32'h02);
    c = cyc;
    ifb.pin_in = 5'h00;
    expect_ev(1'b1, 5'h00, 5'h02, 5'h00, c + 6, c + 8);
    wait_until(c + 12);

    // Simultaneous step on channels 0 and 4.
    c = cyc;
    ifa.pin_in = 5'h11;
    expect_ev(1'b0, 5'h11, 5'h00, 5'h11, c + 6, c + 6);
    wait_until(c + 8);

    // Opposite step, aborted by reset with cnt at 2.
    c = cyc;
    ifa.pin_in = 5'h00;
    wait_until(c + 4);
    chk("midrst_busy_hi", 32'(ifa.busy),    32'h1);
    chk("midrst_lvl_pre", 32'(ifa.lvl_out), 32'h11);
    rst_n = 1'b0;
    wait_until(c + 6);
    chk("midrst_lvl",  32'(ifa.lvl_out), 32'h0);
    chk("midrst_busy", 32'(ifa.busy),    32'h0);
    chk("midrst_fall", 32'(ifa.fall),    32'h0);
    rst_n = 1'b1;
    wait_until(c + 18);
    chk("post_rst_lvl",  32'(ifa.lvl_out), 32'h0);
    chk("post_rst_busy", 32'(ifa.busy),    32'h0);

    chk("a_queue_empty", 32'(qa.size()), 32'h0);
    chk("b_queue_empty", 32'(qb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
